// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding and
// the bit-counter width rule.
package serial_adder_pkg;

  localparam logic [1:0] IDLE_CODE = 2'd0;
  localparam logic [1:0] RUN_CODE  = 2'd1;
  localparam logic [1:0] DONE_CODE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = IDLE_CODE,
    RUN  = RUN_CODE,
    DONE = DONE_CODE
  } state_e;

  // A one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_decoder_cell.sv
// Combinational full adder built from a 3-to-8 one-hot decoder; sum and carry
// are ORs of the matching minterms.
module fa_decoder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  logic [7:0] minterm;

  assign minterm = 8'b0000_0001 << {a_i, b_i, c_i};
  assign sum_o   = minterm[1] | minterm[2] | minterm[4] | minterm[7];
  assign carry_o = minterm[3] | minterm[5] | minterm[6] | minterm[7];

endmodule

// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: one full-adder cell processes a W-bit operation
// LSB first, one bit per clock, and publishes the result with a done strobe.
module serial_adder_sub
  import serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int CW = cnt_width(W);

  state_e          state_q, state_d;
  logic [W-1:0]    sa_q, sa_d;
  logic [W-1:0]    sb_q, sb_d;
  logic [W-1:0]    result_q, result_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            aMsb_q, aMsb_d;
  logic            sbMsb_q, sbMsb_d;
  logic            done_q, done_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            cellSum, cellCarry;

  fa_decoder_cell u_cell (
    .a_i     (sa_q[0]),
    .b_i     (sb_q[0]),
    .c_i     (carry_q),
    .sum_o   (cellSum),
    .carry_o (cellCarry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      result_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      aMsb_q   <= 1'b0;
      sbMsb_q  <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      aMsb_q   <= aMsb_d;
      sbMsb_q  <= sbMsb_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Subtraction is folded into the operand load: B is inverted and the carry
  // flop preset to 1, so the datapath itself only ever adds.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    aMsb_d   = aMsb_q;
    sbMsb_d  = sbMsb_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          aMsb_d  = a[W-1];
          sbMsb_d = sub ? ~b[W-1] : b[W-1];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d = (result_q >> 1) | (W'(cellSum) << (W - 1));
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        carry_d  = cellCarry;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        sum_d   = result_q;
        cout_d  = carry_q;
        ovf_d   = (aMsb_q == sbMsb_q) && (result_q[W-1] != aMsb_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Randomized and directed checks of serial_adder_sub at W=8, 3 and 1 against
// an arithmetic reference model.
module tb_serial_adder_sub;

  logic clk = 1'b0;
  logic rst;

  logic       start8, sub8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start3, sub3, cin3, busy3, done3, cout3, ovf3;
  logic [2:0] a3, b3, sum3;
  logic       start1, sub1, cin1, busy1, done1, cout1, ovf1;
  logic [0:0] a1, b1, sum1;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] prevSum8 = 8'h00;

  always #5 clk = ~clk;

  serial_adder_sub #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder_sub #(.W(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .sub(sub3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .overflow(ovf3)
  );

  serial_adder_sub #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: modular sum plus carry-out, and overflow judged by whether the
  // true signed result fits in w bits.
  function automatic void refModel(input int w, input bit isSub, input longint a,
                                   input longint b, input bit c, output longint rSum,
                                   output bit rCout, output bit rOvf);
    longint mask, half, total, sa, sb, s;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    if (isSub) total = a + ((~b) & mask) + 1;
    else       total = a + b + longint'(c);
    rSum  = total & mask;
    rCout = ((total >> w) & 1) != 0;
    sa = (a >= half) ? a - 2 * half : a;
    sb = (b >= half) ? b - 2 * half : b;
    s  = isSub ? sa - sb : sa + sb + longint'(c);
    rOvf = (s < -half) || (s > half - 1);
  endfunction

  task automatic applyStimulus(input bit isSub, input logic [7:0] a, input logic [7:0] b,
                               input bit c, input int injectAt, input bit checkTail,
                               input string tag);
    longint eSum;
    bit     eCout, eOvf;
    int     cyc, busyCnt, extraDone;
    refModel(8, isSub, longint'(a), longint'(b), c, eSum, eCout, eOvf);
    start8 = 1'b1; sub8 = isSub; a8 = a; b8 = b; cin8 = c;
    @(negedge clk);
    start8 = 1'b0; sub8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    cyc = 0; busyCnt = 0;
    while (!done8 && cyc < 40) begin
      if (cyc == 2) checkOutput({tag, "/held"}, 64'(sum8), 64'(prevSum8));
      if (cyc == injectAt) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
      if (busy8) busyCnt++;
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    checkOutput({tag, "/latency"}, 64'(cyc), 64'(9));
    checkOutput({tag, "/busyCycles"}, 64'(busyCnt), 64'(8));
    checkOutput({tag, "/sum"}, 64'(sum8), 64'(eSum));
    checkOutput({tag, "/cout"}, 64'(cout8), 64'(eCout));
    checkOutput({tag, "/overflow"}, 64'(ovf8), 64'(eOvf));
    prevSum8 = 8'(eSum);
    if (checkTail) begin
      extraDone = 0;
      repeat (4) begin
        @(negedge clk);
        if (done8) extraDone++;
      end
      checkOutput({tag, "/extraDone"}, 64'(extraDone), 64'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint eSum;
    bit     eCout, eOvf;
    int     cyc, doneCnt;

    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start3 = 1'b0; sub3 = 1'b0; cin3 = 1'b0; a3 = '0; b3 = '0;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset/busy", 64'(busy8), 64'(0));
    checkOutput("reset/done", 64'(done8), 64'(0));
    checkOutput("reset/sum", 64'(sum8), 64'(0));
    checkOutput("reset/cout", 64'(cout8), 64'(0));
    checkOutput("reset/overflow", 64'(ovf8), 64'(0));
    checkOutput("reset/sum3", 64'(sum3), 64'(0));
    checkOutput("reset/busy1", 64'(busy1), 64'(0));

    applyStimulus(1'b0, 8'h3C, 8'h1A, 1'b0, -1, 1'b0, "add3C1A");
    applyStimulus(1'b0, 8'hFF, 8'h01, 1'b0, -1, 1'b0, "addFF01");
    applyStimulus(1'b0, 8'h7F, 8'h01, 1'b0, -1, 1'b0, "add7F01");
    applyStimulus(1'b1, 8'h05, 8'h07, 1'b1, -1, 1'b0, "sub0507");
    applyStimulus(1'b1, 8'h80, 8'h01, 1'b0, -1, 1'b0, "sub8001");
    applyStimulus(1'b0, 8'h10, 8'h20, 1'b0, 3, 1'b1, "ignoredStart");

    // Abort an operation four cycles into RUN with a synchronous reset.
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h3C; b8 = 8'h1A; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort/busy", 64'(busy8), 64'(0));
    checkOutput("abort/sum", 64'(sum8), 64'(0));
    checkOutput("abort/done", 64'(done8), 64'(0));
    checkOutput("abort/cout", 64'(cout8), 64'(0));
    doneCnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) doneCnt++;
    end
    checkOutput("abort/noDone", 64'(doneCnt), 64'(0));
    prevSum8 = 8'h00;
    applyStimulus(1'b0, 8'h01, 8'h02, 1'b0, -1, 1'b0, "afterAbort");

    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), -1, 1'b0,
                    "random8");
    end

    // Exhaustive sweeps; each new start follows the done strobe immediately.
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int x = 0; x < 8; x++) begin
          for (int y = 0; y < 8; y++) begin
            refModel(3, 1'(s), longint'(x), longint'(y), 1'(c), eSum, eCout, eOvf);
            start3 = 1'b1; sub3 = 1'(s); cin3 = 1'(c); a3 = 3'(x); b3 = 3'(y);
            @(negedge clk);
            start3 = 1'b0;
            cyc = 0;
            while (!done3 && cyc < 20) begin
              @(negedge clk);
              cyc++;
            end
            checkOutput("w3/latency", 64'(cyc), 64'(4));
            checkOutput("w3/sum", 64'(sum3), 64'(eSum));
            checkOutput("w3/cout", 64'(cout3), 64'(eCout));
            checkOutput("w3/overflow", 64'(ovf3), 64'(eOvf));
          end
        end
      end
    end

    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int x = 0; x < 2; x++) begin
          for (int y = 0; y < 2; y++) begin
            refModel(1, 1'(s), longint'(x), longint'(y), 1'(c), eSum, eCout, eOvf);
            start1 = 1'b1; sub1 = 1'(s); cin1 = 1'(c); a1 = 1'(x); b1 = 1'(y);
            @(negedge clk);
            start1 = 1'b0;
            cyc = 0;
            while (!done1 && cyc < 20) begin
              @(negedge clk);
              cyc++;
            end
            checkOutput("w1/latency", 64'(cyc), 64'(2));
            checkOutput("w1/sum", 64'(sum1), 64'(eSum));
            checkOutput("w1/cout", 64'(cout1), 64'(eCout));
            checkOutput("w1/overflow", 64'(ovf1), 64'(eOvf));
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
